// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite evaluator/arbiter feeding SLOTS renderers from a double-buffered table.
// Optional macro SPRITE_SCHED_ROTATE_EN rotates scan priority by one entry every frame.
module sprite_line_scheduler #(
  parameter int NUM_SPRITES = 8,
  parameter int SLOTS       = 4,
  parameter int SPR_H       = 8,
  parameter int V_ACTIVE    = 720,
  parameter int V_TOTAL     = 750,
  localparam int AW = $clog2(NUM_SPRITES),
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1
) (
  input  logic                 pixelClk,
  input  logic                 reset,
  input  logic signed [9:0]    verticalPix,
  input  logic                 hSync,
  input  logic                 vSync,
  input  logic                 attr_we,
  input  logic [AW-1:0]        attr_addr,
  input  logic [21:0]          attr_wdata,
  output logic                 busy,
  output logic                 slot_load,
  output logic [SW-1:0]        slot_idx,
  output logic [AW-1:0]        slot_id,
  output logic signed [10:0]   slot_x,
  output logic [RW-1:0]        slot_row,
  output logic [SLOTS-1:0]     slot_valid,
  output logic                 overflow
);

  localparam int CW = $clog2(SLOTS + 1);
  localparam logic signed [10:0] ROW_MAX    = 11'(SPR_H - 1);
  localparam logic signed [10:0] LINE_LIMIT = 11'(V_ACTIVE);
  localparam logic [10:0]        LAST_LINE  = 11'(V_TOTAL - 1);
  localparam logic [CW-1:0]      SLOTS_C    = CW'(SLOTS);
  localparam logic [AW-1:0]      LAST_POS   = AW'(NUM_SPRITES - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

  state_t             state_r;
  logic [AW-1:0]      k_r;
  logic [CW-1:0]      cnt_r;
  logic [21:0]        shadow_r [NUM_SPRITES];
  logic [21:0]        active_r [NUM_SPRITES];
  logic               hs_q_r, hs_prev_r, vs_q_r, vs_prev_r;
  logic               hs_rise_s, vs_rise_s;
  logic [AW-1:0]      entry_s;
  logic [21:0]        ent_s;
  logic [10:0]        line_s;
  logic signed [10:0] next_line_s;
  logic signed [10:0] row_s;
  logic               hit_s;

  assign hs_rise_s = hs_q_r & ~hs_prev_r;
  assign vs_rise_s = vs_q_r & ~vs_prev_r;

  // Single registration stage for the timing-generator syncs plus one-deep history.
  always_ff @(posedge pixelClk or posedge reset) begin
    if (reset) begin
      hs_q_r    <= 1'b0;
      hs_prev_r <= 1'b0;
      vs_q_r    <= 1'b0;
      vs_prev_r <= 1'b0;
    end else begin
      hs_q_r    <= hSync;
      hs_prev_r <= hs_q_r;
      vs_q_r    <= vSync;
      vs_prev_r <= vs_q_r;
    end
  end

`ifdef SPRITE_SCHED_ROTATE_EN
  logic [AW-1:0] rot_r;

  // Rotation offset advances with each frame commit so dropped sprites take turns.
  always_ff @(posedge pixelClk or posedge reset) begin
    if (reset) begin
      rot_r <= {AW{1'b0}};
    end else if (vs_rise_s) begin
      rot_r <= rot_r + AW'(1);
    end
  end

  assign entry_s = rot_r + k_r;
`else
  assign entry_s = k_r;
`endif

  // Shadow takes CPU writes; active snapshots shadow at frame start (a same-cycle write misses it).
  always_ff @(posedge pixelClk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_r[i] <= 22'd0;
        active_r[i] <= 22'd0;
      end
    end else begin
      if (vs_rise_s) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          active_r[i] <= shadow_r[i];
        end
      end
      if (attr_we) begin
        shadow_r[attr_addr] <= attr_wdata;
      end
    end
  end

  // Hit test of the entry at the current scan position against the upcoming line.
  always_comb begin
    line_s = {1'b0, verticalPix};
    ent_s  = active_r[entry_s];
    if (line_s == LAST_LINE) begin
      next_line_s = 11'sd0;
    end else begin
      next_line_s = $signed(line_s) + 11'sd1;
    end
    row_s = next_line_s - $signed({ent_s[9], ent_s[9:0]});
    hit_s = ent_s[21] && (row_s >= 11'sd0) && (row_s <= ROW_MAX) && (next_line_s < LINE_LIMIT);
  end

  // Scan FSM: one table position per cycle, loading hits into free slots in priority order.
  always_ff @(posedge pixelClk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      k_r        <= {AW{1'b0}};
      cnt_r      <= {CW{1'b0}};
      busy       <= 1'b0;
      slot_load  <= 1'b0;
      slot_idx   <= {SW{1'b0}};
      slot_id    <= {AW{1'b0}};
      slot_x     <= 11'sd0;
      slot_row   <= {RW{1'b0}};
      slot_valid <= {SLOTS{1'b0}};
      overflow   <= 1'b0;
    end else begin
      slot_load <= 1'b0;
      if (vs_rise_s) begin
        overflow <= 1'b0;
      end
      if (hs_rise_s) begin
        // A new line start while scanning means the previous line's result is incomplete.
        if (state_r == S_SCAN) begin
          overflow <= 1'b1;
        end
        state_r    <= S_SCAN;
        busy       <= 1'b1;
        k_r        <= {AW{1'b0}};
        cnt_r      <= {CW{1'b0}};
        slot_valid <= {SLOTS{1'b0}};
      end else begin
        case (state_r)
          S_IDLE: begin
            busy <= 1'b0;
          end
          S_SCAN: begin
            if (hit_s) begin
              if (cnt_r < SLOTS_C) begin
                slot_load               <= 1'b1;
                slot_idx                <= cnt_r[SW-1:0];
                slot_id                 <= entry_s;
                slot_x                  <= $signed(ent_s[20:10]);
                slot_row                <= row_s[RW-1:0];
                slot_valid[cnt_r[SW-1:0]] <= 1'b1;
                cnt_r                   <= cnt_r + CW'(1);
              end else begin
                overflow <= 1'b1;
              end
            end
            if (k_r == LAST_POS) begin
              state_r <= S_IDLE;
              busy    <= 1'b0;
            end else begin
              k_r <= k_r + AW'(1);
            end
          end
          default: begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Randomized self-checking bench for sprite_line_scheduler against a line-level hit-list model.
module tb_sprite_line_scheduler;
  localparam int NS = 8;
  localparam int SL = 4;
  localparam int SH = 8;

  logic               pixelClk = 1'b0;
  logic               reset;
  logic signed [9:0]  verticalPix;
  logic               hSync, vSync, attr_we;
  logic [2:0]         attr_addr;
  logic [21:0]        attr_wdata;
  logic               busy, slot_load, overflow;
  logic [1:0]         slot_idx;
  logic [2:0]         slot_id;
  logic signed [10:0] slot_x;
  logic [2:0]         slot_row;
  logic [3:0]         slot_valid;

  int errors = 0;
  int checks = 0;
  int sh_en[NS], sh_x[NS], sh_y[NS];
  int ac_en[NS], ac_x[NS], ac_y[NS];
  int rot_m, ovf_m, cur_vp;

  sprite_line_scheduler dut (
    .pixelClk(pixelClk), .reset(reset), .verticalPix(verticalPix), .hSync(hSync), .vSync(vSync),
    .attr_we(attr_we), .attr_addr(attr_addr), .attr_wdata(attr_wdata), .busy(busy),
    .slot_load(slot_load), .slot_idx(slot_idx), .slot_id(slot_id), .slot_x(slot_x),
    .slot_row(slot_row), .slot_valid(slot_valid), .overflow(overflow)
  );

  always #5 pixelClk = ~pixelClk;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      sh_en[i] = 0; sh_x[i] = 0; sh_y[i] = 0;
      ac_en[i] = 0; ac_x[i] = 0; ac_y[i] = 0;
    end
    rot_m = 0; ovf_m = 0;
  endtask

  task automatic wr(input int a, input int en, input int x, input int y);
    logic [10:0] xs;
    logic [9:0]  ys;
    xs = x[10:0];
    ys = y[9:0];
    @(negedge pixelClk);
    attr_we = 1'b1; attr_addr = a[2:0]; attr_wdata = {en[0], xs, ys};
    @(negedge pixelClk);
    attr_we = 1'b0;
    sh_en[a] = en; sh_x[a] = x; sh_y[a] = y;
  endtask

  task automatic clear_table();
    for (int i = 0; i < NS; i++) wr(i, 0, 0, 0);
  endtask

  task automatic vsync_pulse();
    @(negedge pixelClk); vSync = 1'b1;
    @(negedge pixelClk);
    @(negedge pixelClk); vSync = 1'b0;
    @(negedge pixelClk);
    for (int i = 0; i < NS; i++) begin
      ac_en[i] = sh_en[i]; ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i];
    end
`ifdef SPRITE_SCHED_ROTATE_EN
    rot_m = (rot_m + 1) % NS;
`endif
    ovf_m = 0;
  endtask

  // Leaves the bench on the negedge right after the scan-start edge.
  task automatic start_hsync(input int vp);
    @(negedge pixelClk);
    verticalPix = 10'(vp); cur_vp = vp; hSync = 1'b1;
    @(negedge pixelClk);
    @(negedge pixelClk); hSync = 1'b0;
  endtask

  task automatic collect(input string nm);
    bit ld[NS];
    int lid[NS], lidx[NS], lrow[NS];
    int n, nl, row, e, exp_valid;
    bit exp_ld;
    logic [18:0] exp_vec;
    n = 0;
    nl = (cur_vp == 749) ? 0 : cur_vp + 1;
    for (int k = 0; k < NS; k++) begin
      ld[k] = 0; lid[k] = 0; lidx[k] = 0; lrow[k] = 0;
      e = (rot_m + k) % NS;
      row = nl - ac_y[e];
      if (ac_en[e] != 0 && row >= 0 && row < SH && nl < 720) begin
        if (n < SL) begin
          ld[k] = 1; lid[k] = e; lidx[k] = n; lrow[k] = row; n++;
        end else begin
          ovf_m = 1;
        end
      end
    end
    exp_valid = (1 << n) - 1;
    for (int t = 0; t <= NS; t++) begin
      checks++;
      if (busy !== (t < NS)) begin
        errors++; $display("FAIL %s busy t=%0d: got %b want %b", nm, t, busy, (t < NS));
      end
      exp_ld = (t >= 1) ? ld[t-1] : 1'b0;
      checks++;
      if (slot_load !== exp_ld) begin
        errors++; $display("FAIL %s slot_load t=%0d: got %b want %b", nm, t, slot_load, exp_ld);
      end
      if (exp_ld) begin
        exp_vec = {2'(lidx[t-1]), 3'(lid[t-1]), 11'(ac_x[lid[t-1]]), 3'(lrow[t-1])};
        checks++;
        if ({slot_idx, slot_id, slot_x, slot_row} !== exp_vec) begin
          errors++;
          $display("FAIL %s load t=%0d: got idx=%0d id=%0d x=%0d row=%0d want idx=%0d id=%0d x=%0d row=%0d",
                   nm, t, slot_idx, slot_id, slot_x, slot_row, lidx[t-1], lid[t-1], ac_x[lid[t-1]], lrow[t-1]);
        end
      end
      @(negedge pixelClk);
    end
    checks++;
    if (slot_valid !== 4'(exp_valid)) begin
      errors++; $display("FAIL %s slot_valid: got %b want %b", nm, slot_valid, 4'(exp_valid));
    end
    checks++;
    if (overflow !== 1'(ovf_m)) begin
      errors++; $display("FAIL %s overflow: got %b want %0d", nm, overflow, ovf_m);
    end
  endtask

  task automatic scan(input string nm, input int vp);
    start_hsync(vp);
    collect(nm);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge pixelClk);
    checks++;
    if ({busy, slot_load, overflow, slot_valid} !== 7'd0) begin
      errors++; $display("FAIL reset_flags: got %b want 0", {busy, slot_load, overflow, slot_valid});
    end
    checks++;
    if ({slot_idx, slot_id, slot_x, slot_row} !== 19'd0) begin
      errors++; $display("FAIL reset_slot: got %h want 0", {slot_idx, slot_id, slot_x, slot_row});
    end
    reset = 1'b0;
    model_reset();
    scan("empty_scan", 100);
  endtask

  task automatic test_single();
    wr(0, 1, 100, 10);
    vsync_pulse();
    scan("single", 12);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) wr(i, 1, i * 7, 20);
    vsync_pulse();
    scan("overflow", 19);
    vsync_pulse();
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL overflow_clear: got %b want 0", overflow);
    end
  endtask

  task automatic test_edges();
    clear_table();
    wr(0, 1, 5, -3);
    vsync_pulse();
    scan("wrap_line", 749);
    clear_table();
    wr(0, 1, 9, 0);
    wr(1, 1, 300, 500);
    vsync_pulse();
    scan("row_beyond", 7);
    scan("row_last", 6);
    scan("line_719", 719);
  endtask

  task automatic test_shadow();
    clear_table();
    wr(2, 1, 33, 40);
    vsync_pulse();
    scan("shadow_a", 42);
    wr(2, 1, -77, 200);
    scan("shadow_same_frame", 42);
    vsync_pulse();
    scan("shadow_old_pos", 42);
    scan("shadow_new_pos", 199);
  endtask

  task automatic test_abort();
    clear_table();
    wr(1, 1, 11, 60);
    wr(6, 1, 22, 58);
    vsync_pulse();
    @(negedge pixelClk);
    verticalPix = 10'(60); cur_vp = 60; hSync = 1'b1;
    @(negedge pixelClk);
    @(negedge pixelClk); hSync = 1'b0;
    @(negedge pixelClk); hSync = 1'b1;
    @(negedge pixelClk);
    @(negedge pixelClk); hSync = 1'b0;
    ovf_m = 1;
    collect("abort_restart");
  endtask

  task automatic test_frames();
    clear_table();
    for (int i = 0; i < 6; i++) wr(i, 1, i * 10 - 30, 300);
    vsync_pulse();
    for (int f = 0; f < 6; f++) begin
      scan("frame_rot", 300 + (f % 3));
      vsync_pulse();
    end
  endtask

  task automatic test_random();
    int base;
    base = $urandom_range(20, 480);
    for (int it = 0; it < 25; it++) begin
      for (int w = 0; w < $urandom_range(1, 4); w++) begin
        wr($urandom_range(0, NS - 1), ($urandom_range(0, 3) != 0) ? 1 : 0,
           $urandom_range(0, 2047) - 1024, base + $urandom_range(0, 14) - 7);
      end
      if ($urandom_range(0, 1) == 1) vsync_pulse();
      scan("random", base + $urandom_range(0, 16) - 9);
    end
  endtask

  task automatic test_reset_mid_scan();
    clear_table();
    for (int i = 0; i < NS; i++) wr(i, 1, i, 100);
    vsync_pulse();
    start_hsync(100);
    repeat (3) @(negedge pixelClk);
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, slot_load, slot_valid, overflow} !== 7'd0) begin
      errors++; $display("FAIL reset_mid_scan: got %b want 0", {busy, slot_load, slot_valid, overflow});
    end
    @(negedge pixelClk);
    reset = 1'b0;
    model_reset();
    for (int t = 0; t < 6; t++) begin
      @(negedge pixelClk);
      checks++;
      if ({busy, slot_load} !== 2'b00) begin
        errors++; $display("FAIL post_reset_quiet t=%0d: got %b want 00", t, {busy, slot_load});
      end
    end
    scan("after_reset", 100);
  endtask

  initial begin
    reset = 1'b1; verticalPix = 10'd0; hSync = 1'b0; vSync = 1'b0;
    attr_we = 1'b0; attr_addr = 3'd0; attr_wdata = 22'd0; cur_vp = 0;
    model_reset();
    test_reset();
    test_single();
    test_overflow();
    test_edges();
    test_shadow();
    test_abort();
    test_frames();
    test_random();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline sprite evaluator/arbiter sitting between a sprite attribute source (button/CPU logic) and a bank of SLOTS per-slot sprite renderers in the HDMI pixel pipeline.
- Holds a double-buffered attribute table of NUM_SPRITES entries, committed at frame start.
- At each hSync rising edge it scans the table, finds the sprites intersecting the next scanline, and loads up to SLOTS of them into renderer slots by fixed priority, flagging overflow.

Parameters:
- NUM_SPRITES, 8, attribute table entries; power of two, 2..16.
- SLOTS, 4, renderer slots per line; 1..NUM_SPRITES.
- SPR_H, 8, sprite height in lines.
- V_ACTIVE, 720, visible lines.
- V_TOTAL, 750, total lines per frame.

Ports:
- pixelClk  in  1  pixel clock; sole clock.
- reset  in  1  asynchronous, active-high reset.
- verticalPix  in  10 signed  current line from the HDMI timing generator.
- hSync  in  1  horizontal sync from the timing generator.
- vSync  in  1  vertical sync from the timing generator.
- attr_we  in  1  shadow-table write strobe.
- attr_addr  in  log2(NUM_SPRITES)  entry index.
- attr_wdata  in  22  {enable[21], x[20:10] signed, y[9:0] signed}.
- busy  out  1  scan in progress.
- slot_load  out  1  one-cycle load strobe to renderers.
- slot_idx  out  log2(SLOTS)  target slot.
- slot_id  out  log2(NUM_SPRITES)  sprite index loaded.
- slot_x  out  11 signed  sprite left X.
- slot_row  out  log2(SPR_H)  bitmap row to draw.
- slot_valid  out  SLOTS  slots holding a sprite for this line.
- overflow  out  1  sticky per frame: more than SLOTS hits on some line.

Behaviour:
- Reset (async): all outputs 0; FSM IDLE; both tables cleared with enable=0; registered sync copies 0.
- hSync and vSync are registered once. A rise is the current sample 1 with the previous sample 0.
- Writes: attr_we writes the shadow table only. Scans always read the active table.
- Commit: on a vSync rise, active table <= shadow table and overflow <= 0.
  - A write in the commit cycle lands in shadow only, so it becomes visible next frame.
- Line selection: nextLine = (verticalPix == V_TOTAL-1) ? 0 : verticalPix+1.
- Hit test for entry e, computed in 11-bit signed: row = nextLine - e.y.
  - Hit when e.enable=1, 0 <= row <= SPR_H-1, and nextLine < V_ACTIVE.
  - Negative y is legal, giving partially off-top sprites.
- FSM:
  - IDLE -> SCAN on an hSync rise, at edge E0.
    - At E0: slot_valid <= 0, slot counter <= 0, position k <= 0.
  - SCAN evaluates position k = 0..NUM_SPRITES-1, one per cycle, in priority order (lower index = higher priority).
    - On a hit with slots free: after edge E0+1+k, slot_load=1 for one cycle with slot_idx = slot counter, slot_id, slot_x, slot_row = row[log2(SPR_H)-1:0]. slot_valid[slot_idx] is set on the same edge and the slot counter increments.
    - On a hit with all SLOTS used: no load; overflow <= 1.
  - After the last position: SCAN -> IDLE at edge E0+NUM_SPRITES.
- busy = (state == SCAN): high after E0, low after E0+NUM_SPRITES.
- slot_valid holds until the next scan start.
- Simultaneous vSync rise and hSync rise: the commit happens on that edge and the scan starting there reads the newly committed table.
- hSync rise while busy: abort, restart at position 0 with slot_valid cleared, overflow <= 1.
- reset mid-scan: immediate return to the reset state; no further slot_load.

Optional Feature:
- Macro SPRITE_SCHED_ROTATE_EN.
  - Defined: a rotation register rot (log2(NUM_SPRITES) bits, reset 0) increments modulo NUM_SPRITES on each vSync rise, in the same edge as the commit.
    - Scan position k evaluates entry (rot+k) mod NUM_SPRITES.
    - Effect: over-limit sprites flicker instead of permanently dropping.
  - Undefined: position k evaluates entry k and no rotation register exists.

Test Plan:
- Reset asserted -> all outputs 0; with no writes, an hSync rise gives busy for 8 cycles, no slot_load, slot_valid=0000.
- Write entry 0 = {1, x=100, y=10}; vSync pulse; hSync rise at verticalPix=12 -> exactly one slot_load, one cycle after E0, with slot_idx=0, slot_id=0, slot_x=100, slot_row=3; slot_valid=0001.
- Entries 0..5 all enabled, y=20; scan at verticalPix=19 -> loads ids 0,1,2,3 into slots 0..3; slot_valid=1111; overflow=1; next vSync rise -> overflow=0.
- Edge cases:
  - Entry y=-3 with verticalPix=749 -> nextLine 0, hit, slot_row=3.
  - Entry y=0 with verticalPix=7 -> row 8, no hit.
  - verticalPix=719 -> no hits.
- Shadow isolation and reset mid-scan:
  - Write entry 2 mid-frame -> scans in the same frame are unaffected; visible after the next vSync rise.
  - reset pulsed 3 cycles into a scan -> slot_load never asserts again and busy=0 immediately.
- SPRITE_SCHED_ROTATE_EN with 6 hits, 4 slots -> frame 0 loads ids 0-3, frame 1 loads ids 1-4, frame 5 loads 5,6,7,0 order-filtered to hits (5,0,1,2).
